// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide unit: MDUOp codes, FSM states
// and small decode helpers used by the unit and by the control logic.
package mdu_pkg;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  // Multiplies and divides are exactly the codes with op[2] clear.
  function automatic logic is_muldiv(input logic [2:0] op);
    return (op[2] == 1'b0);
  endfunction

  function automatic logic is_div(input logic [2:0] op);
    return (op[2] == 1'b0) && op[1];
  endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational multiply/divide result for latched operands, including
// the divide-by-zero and signed-overflow results.
module mdu_calc
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [2:0]       i_op,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic signed [2*WIDTH-1:0] w_prod_s;
  logic [2*WIDTH-1:0]        w_prod_u;
  logic                      w_a_neg;
  logic                      w_b_neg;
  logic [WIDTH-1:0]          w_a_mag;
  logic [WIDTH-1:0]          w_b_mag;
  logic [WIDTH-1:0]          w_q_mag;
  logic [WIDTH-1:0]          w_r_mag;
  logic [WIDTH-1:0]          w_q;
  logic [WIDTH-1:0]          w_r;
  logic                      w_ovf;

  assign w_prod_s = $signed({{WIDTH{i_a[WIDTH-1]}}, i_a}) * $signed({{WIDTH{i_b[WIDTH-1]}}, i_b});
  assign w_prod_u = {{WIDTH{1'b0}}, i_a} * {{WIDTH{1'b0}}, i_b};

  // Signed divide runs on magnitudes so a single unsigned divider serves both
  // ops; quotient truncates toward zero and the remainder follows the dividend.
  assign w_a_neg = (i_op == OP_DIV) && i_a[WIDTH-1];
  assign w_b_neg = (i_op == OP_DIV) && i_b[WIDTH-1];
  assign w_a_mag = w_a_neg ? -i_a : i_a;
  assign w_b_mag = w_b_neg ? -i_b : i_b;
  assign w_q_mag = w_a_mag / w_b_mag;
  assign w_r_mag = w_a_mag % w_b_mag;
  assign w_q     = (w_a_neg ^ w_b_neg) ? -w_q_mag : w_q_mag;
  assign w_r     = w_a_neg ? -w_r_mag : w_r_mag;
  assign w_ovf   = (i_op == OP_DIV) && (i_a == MOST_NEG) && (i_b == '1);

  always_comb begin
    o_hi = '0;
    o_lo = '0;
    case (i_op)
      OP_MULT:  {o_hi, o_lo} = w_prod_s;
      OP_MULTU: {o_hi, o_lo} = w_prod_u;
      OP_DIV, OP_DIVU: begin
        if (i_b == '0) begin
          o_hi = i_a;
          o_lo = '1;
        end else if (w_ovf) begin
          o_hi = '0;
          o_lo = i_a;
        end else begin
          o_hi = w_r;
          o_lo = w_q;
        end
      end
      default: begin
        o_hi = '0;
        o_lo = '0;
      end
    endcase
  end

endmodule

// File: rtl/mdu_seq.sv
// Multi-cycle multiply/divide unit: IDLE/BUSY FSM with a latency counter,
// operand latches and the architectural HI/LO registers.
module mdu_seq
  import mdu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       MDUOp,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int CNT_MAX = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_done;

  logic             w_accept;
  logic             w_finish;
  logic             w_busy;
  logic             w_mthi;
  logic             w_mtlo;
  logic [WIDTH-1:0] w_res_hi;
  logic [WIDTH-1:0] w_res_lo;

  mdu_calc #(
    .WIDTH (WIDTH)
  ) u_calc (
    .i_a  (r_a),
    .i_b  (r_b),
    .i_op (r_op),
    .o_hi (w_res_hi),
    .o_lo (w_res_lo)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // The last busy edge is the one that sees the counter at 1.
  always_comb begin
    w_accept     = (r_state == S_IDLE) && start && is_muldiv(MDUOp);
    w_finish     = (r_state == S_BUSY) && (r_cnt == CW'(1));
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_next = S_BUSY;
      S_BUSY:  if (w_finish) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy = (r_state == S_BUSY);
    w_mthi = (r_state == S_IDLE) && start && (MDUOp == OP_MTHI);
    w_mtlo = (r_state == S_IDLE) && start && (MDUOp == OP_MTLO);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt  <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_op   <= OP_MULT;
      r_hi   <= '0;
      r_lo   <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_finish;
      if (w_accept) begin
        r_a   <= A;
        r_b   <= B;
        r_op  <= MDUOp;
        r_cnt <= is_div(MDUOp) ? CW'(DIV_CYCLES) : CW'(MUL_CYCLES);
      end else if (w_busy) begin
        r_cnt <= r_cnt - CW'(1);
      end
      if (w_finish) begin
        r_hi <= w_res_hi;
        r_lo <= w_res_lo;
      end else begin
        if (w_mthi) r_hi <= A;
        if (w_mtlo) r_lo <= A;
      end
    end
  end

  assign busy = w_busy;
  assign done = r_done;
  assign HI   = r_hi;
  assign LO   = r_lo;

endmodule
